conv2d_stream_engine: RTL and testbench

- Parametrised successor to the fixed 28x28 / 3x3 convolution controller.
- Loads a KxK signed kernel at run time, then buffers an IMG_DIM x IMG_DIM unsigned image through a valid/ready stream.
- Computes a valid-padding 2-D convolution with configurable stride using one sequential multiply-accumulate per cycle.
- Streams results out under valid/ready backpressure, with optional ReLU. Sits between the pixel source and the pooling stage.

---
 rtl/conv2d_stream_engine.sv | 202 ++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: run-time loadable KxK signed kernel, buffered
// IMG_DIM x IMG_DIM unsigned image, valid-padding strided 2-D convolution
// with one multiply-accumulate per cycle and a valid/ready result stream.
module conv2d_stream_engine #(
  parameter  int IMG_DIM = 28,
  parameter  int K       = 3,
  parameter  int STRIDE  = 1,
  parameter  int PIX_W   = 8,
  parameter  int KW_W    = 8,
  localparam int N       = IMG_DIM * IMG_DIM,
  localparam int OD      = (IMG_DIM - K) / STRIDE + 1,
  localparam int ACC_W   = PIX_W + KW_W + $clog2(K * K) + 1,
  localparam int OW      = $clog2(OD) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    keep_kernel,
  input  logic                    relu_en,
  input  logic [KW_W-1:0]         kw_in,
  input  logic                    kw_valid,
  output logic                    kw_ready,
  input  logic [PIX_W-1:0]        pixel_in,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  output logic signed [ACC_W-1:0] conv_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OW-1:0]           out_row,
  output logic [OW-1:0]           out_col,
  output logic                    load_done,
  output logic                    busy,
  output logic                    done
);

  localparam int KK  = K * K;
  localparam int KA  = (KK > 1) ? $clog2(KK) : 1;
  localparam int AW  = (N > 1) ? $clog2(N) : 1;
  localparam int KCW = $clog2(KK + 1);
  localparam int PCW = $clog2(N + 1);
  localparam int TW  = $clog2(K) + 1;

  if (K < 1) begin : g_bad_k
    $error("conv2d_stream_engine: K must be >= 1");
  end
  if (((IMG_DIM - K) % STRIDE) != 0) begin : g_bad_stride
    $error("conv2d_stream_engine: (IMG_DIM-K) must be a multiple of STRIDE");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KERNEL,
    LOAD_IMAGE,
    COMPUTE,
    OUTPUT,
    DONE
  } state_t;

  state_t                    state;
  logic signed [KW_W-1:0]    ker_mem [KK];
  logic [PIX_W-1:0]          img_mem [N];
  logic                      kernel_loaded;
  logic                      relu_q;
  logic [KCW-1:0]            kcnt;
  logic [PCW-1:0]            pcnt;
  logic [TW-1:0]             ki;
  logic [TW-1:0]             kj;
  logic [KA-1:0]             tap;
  logic [OW-1:0]             r;
  logic [OW-1:0]             c;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [PIX_W+KW_W:0] prod;
  logic [AW-1:0]             pix_addr;
  logic                      last_tap;

  assign kw_ready    = (state == LOAD_KERNEL);
  assign pixel_ready = (state == LOAD_IMAGE);
  assign busy        = (state != IDLE);

  // Current tap address inside the window and the running MAC sum.
  always_comb begin
    pix_addr = AW'((32'(r) * 32'(STRIDE) + 32'(ki)) * 32'(IMG_DIM)
                   + 32'(c) * 32'(STRIDE) + 32'(kj));
    prod     = $signed({1'b0, img_mem[pix_addr]}) * ker_mem[tap];
    acc_sum  = acc + ACC_W'(prod);
    last_tap = (tap == KA'(KK - 1));
  end

  // Kernel and image storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && state == LOAD_KERNEL && kw_valid)
      ker_mem[kcnt[KA-1:0]] <= kw_in;
    if (rst && state == LOAD_IMAGE && pixel_valid)
      img_mem[pcnt[AW-1:0]] <= pixel_in;
  end

  // Job control FSM with registered result, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      kernel_loaded <= 1'b0;
      relu_q        <= 1'b0;
      kcnt          <= '0;
      pcnt          <= '0;
      ki            <= '0;
      kj            <= '0;
      tap           <= '0;
      r             <= '0;
      c             <= '0;
      acc           <= '0;
      conv_out      <= '0;
      out_valid     <= 1'b0;
      out_row       <= '0;
      out_col       <= '0;
      load_done     <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            relu_q    <= relu_en;
            load_done <= 1'b0;
            kcnt      <= '0;
            pcnt      <= '0;
            r         <= '0;
            c         <= '0;
            state     <= (keep_kernel && kernel_loaded) ? LOAD_IMAGE : LOAD_KERNEL;
          end
        end
        LOAD_KERNEL: begin
          if (kw_valid) begin
            kcnt <= kcnt + 1'b1;
            if (kcnt == KCW'(KK - 1)) begin
              kernel_loaded <= 1'b1;
              state         <= LOAD_IMAGE;
            end
          end
        end
        LOAD_IMAGE: begin
          if (pixel_valid) begin
            pcnt <= pcnt + 1'b1;
            if (pcnt == PCW'(N - 1)) begin
              load_done <= 1'b1;
              acc       <= '0;
              tap       <= '0;
              ki        <= '0;
              kj        <= '0;
              state     <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          acc <= acc_sum;
          tap <= tap + 1'b1;
          if (kj == TW'(K - 1)) begin
            kj <= '0;
            ki <= ki + 1'b1;
          end else begin
            kj <= kj + 1'b1;
          end
          if (last_tap) begin
            conv_out  <= (relu_q && acc_sum[ACC_W-1]) ? '0 : acc_sum;
            out_row   <= r;
            out_col   <= c;
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            tap       <= '0;
            ki        <= '0;
            kj        <= '0;
            if (c == OW'(OD - 1)) begin
              c <= '0;
              if (r == OW'(OD - 1)) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                r     <= r + 1'b1;
                state <= COMPUTE;
              end
            end else begin
              c     <= c + 1'b1;
              state <= COMPUTE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench for conv2d_stream_engine: table-driven constant-result
// jobs, a randomized job against a loop-based reference convolution, a
// strided small instance, and reset/backpressure corner sequences.
module tb_conv2d_stream_engine;

  localparam int D    = 28;
  localparam int KS   = 3;
  localparam int OD   = 26;
  localparam int NPIX = D * D;
  localparam int NOUT = OD * OD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  // default-size instance
  logic        start, keep_kernel, relu_en, kw_valid, kw_ready;
  logic [7:0]  kw_in, pixel_in;
  logic        pixel_valid, pixel_ready, out_valid, out_ready;
  logic signed [20:0] conv_out;
  logic [5:0]  out_row, out_col;
  logic        load_done, busy, done;
  // strided small instance
  logic        start_s, keep_s, relu_s, kw_valid_s, kw_ready_s;
  logic [7:0]  kw_in_s, pixel_in_s;
  logic        pixel_valid_s, pixel_ready_s, out_valid_s, out_ready_s;
  logic signed [20:0] conv_out_s;
  logic [2:0]  out_row_s, out_col_s;
  logic        load_done_s, busy_s, done_s;

  conv2d_stream_engine dut (
    .clk(clk), .rst(rst), .start(start), .keep_kernel(keep_kernel),
    .relu_en(relu_en), .kw_in(kw_in), .kw_valid(kw_valid), .kw_ready(kw_ready),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .conv_out(conv_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .load_done(load_done),
    .busy(busy), .done(done)
  );

  conv2d_stream_engine #(.IMG_DIM(7), .K(3), .STRIDE(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .keep_kernel(keep_s),
    .relu_en(relu_s), .kw_in(kw_in_s), .kw_valid(kw_valid_s), .kw_ready(kw_ready_s),
    .pixel_in(pixel_in_s), .pixel_valid(pixel_valid_s), .pixel_ready(pixel_ready_s),
    .conv_out(conv_out_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_row(out_row_s), .out_col(out_col_s), .load_done(load_done_s),
    .busy(busy_s), .done(done_s)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int img[];
  int ker[];
  int exp_q[$];

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference: direct sum over every window, ReLU applied afterwards.
  task automatic model(input int d, input int k, input int s, input bit relu);
    int od, sum;
    od = (d - k) / s + 1;
    exp_q.delete();
    for (int r = 0; r < od; r++)
      for (int c = 0; c < od; c++) begin
        sum = 0;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            sum += img[(r * s + i) * d + c * s + j] * ker[i * k + j];
        if (relu && sum < 0) sum = 0;
        exp_q.push_back(sum);
      end
  endtask

  // One job on the default instance; tasks start and end 1 time unit after a rising edge.
  task automatic run_job(input bit keep, input bit relu, input bit exp_kw,
                         input int gap_pct, input int ready_pct, input int hold_k,
                         input int stop_k, input bit chk_spacing,
                         input bit has_const, input int const_val);
    int i, guard, w, hold, last;
    bit hs, got, ld_chk;
    start = 1'b1; keep_kernel = keep; relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
    check("kw_ready_after_start", kw_ready, exp_kw);
    check("load_done_cleared", load_done, 0);
    check("busy_after_start", busy, 1);
    if (exp_kw) begin
      i = 0; guard = 0;
      while (i < KS * KS && guard < 1000) begin
        kw_valid = ($urandom_range(99) >= gap_pct);
        kw_in = 8'(ker[i]);
        hs = kw_valid && kw_ready;
        @(posedge clk); #1;
        if (hs) i++;
        guard++;
      end
      kw_valid = 1'b0;
      if (i < KS * KS) begin timeout("kernel_load"); return; end
    end
    check("kw_ready_in_image", kw_ready, 0);
    check("pixel_ready_in_image", pixel_ready, 1);
    i = 0; guard = 0; ld_chk = 0;
    while (i < NPIX && guard < 20000) begin
      pixel_valid = ($urandom_range(99) >= gap_pct);
      pixel_in = 8'(img[i]);
      if (i == NPIX - 1 && !ld_chk) begin
        check("load_done_before_last", load_done, 0);
        ld_chk = 1;
      end
      hs = pixel_valid && pixel_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    pixel_valid = 1'b0;
    if (i < NPIX) begin timeout("image_load"); return; end
    check("load_done_after_last", load_done, 1);
    check("pixel_ready_after_load", pixel_ready, 0);
    last = 0;
    for (int k = 0; k < NOUT && k < stop_k; k++) begin
      got = 0; w = 0; hold = 0;
      while (!got && w < 200) begin
        if (k == hold_k && out_valid && hold < 10) begin
          out_ready = 1'b0;
          check("hold_valid", out_valid, 1);
          check("hold_value", conv_out, exp_q[k]);
          check("hold_col", out_col, k % OD);
          hold++;
        end else begin
          out_ready = ($urandom_range(99) < ready_pct);
        end
        if (done) check("done_early", done, 0);
        if (out_valid && out_ready) begin
          check("conv_out", conv_out, exp_q[k]);
          check("out_row", out_row, k / OD);
          check("out_col", out_col, k % OD);
          if (has_const) check("conv_out_const", conv_out, const_val);
          if (chk_spacing && k > 0) check("result_spacing", cyc - last, 10);
          last = cyc;
          got = 1;
        end
        @(posedge clk); #1;
        w++;
      end
      if (!got) begin out_ready = 1'b0; timeout("result_wait"); return; end
    end
    out_ready = 1'b0;
    if (stop_k >= NOUT) begin
      check("done_pulse", done, 1);
      @(posedge clk); #1;
      check("done_falls", done, 0);
      check("busy_idle", busy, 0);
    end
  endtask

  typedef struct {
    int kmode;     // 0: all 1, 1: centre -128, 2: all -128
    int pmode;     // 0: all 1, 1: all 255
    bit relu;
    bit keep;
    bit exp_kw;
    int exp_val;
    bit spacing;
  } vec_t;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int w, k;
    bit hs;
    tbl[0] = '{0, 0, 1'b0, 1'b0, 1'b1, 9,       1'b1};
    tbl[1] = '{1, 1, 1'b0, 1'b0, 1'b1, -32640,  1'b0};
    tbl[2] = '{1, 1, 1'b1, 1'b1, 1'b0, 0,       1'b0};
    tbl[3] = '{2, 1, 1'b0, 1'b0, 1'b1, -293760, 1'b0};

    rst = 1'b0;
    start = 0; keep_kernel = 0; relu_en = 0; kw_in = 0; kw_valid = 0;
    pixel_in = 0; pixel_valid = 0; out_ready = 0;
    start_s = 0; keep_s = 0; relu_s = 0; kw_in_s = 0; kw_valid_s = 0;
    pixel_in_s = 0; pixel_valid_s = 0; out_ready_s = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_conv_out", conv_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_done", load_done, 0);
    check("rst_kw_ready", kw_ready, 0);
    check("rst_pixel_ready", pixel_ready, 0);
    check("rst_out_row", out_row, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    img = new[NPIX];
    ker = new[KS * KS];
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < KS * KS; i++)
        ker[i] = (tbl[v].kmode == 0) ? 1 : (tbl[v].kmode == 2) ? -128 : (i == 4) ? -128 : 0;
      for (int i = 0; i < NPIX; i++)
        img[i] = (tbl[v].pmode == 0) ? 1 : 255;
      model(D, KS, 1, tbl[v].relu);
      run_job(tbl[v].keep, tbl[v].relu, tbl[v].exp_kw, 0, 100, -1, NOUT,
              tbl[v].spacing, 1'b1, tbl[v].exp_val);
    end

    // Randomized job: gapped loading, random backpressure, 10-cycle stall at (0,3).
    for (int i = 0; i < KS * KS; i++) ker[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
    model(D, KS, 1, 1'b1);
    run_job(1'b0, 1'b1, 1'b1, 40, 60, 3, NOUT, 1'b0, 1'b0, 0);

    // Reset during COMPUTE of (5,7): abort without done, kernel_loaded cleared.
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
    model(D, KS, 1, 1'b0);
    run_job(1'b1, 1'b0, 1'b0, 0, 100, -1, 5 * OD + 7, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_conv_out", conv_out, 0);
    check("abort_out_row", out_row, 0);
    check("abort_out_col", out_col, 0);
    check("abort_load_done", load_done, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) check("abort_no_done", done, 0);
    end
    start = 1'b1; keep_kernel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("kernel_flag_cleared", kw_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Small strided instance: 7x7 image of index values, all-ones kernel.
    img = new[49];
    for (int i = 0; i < 49; i++) img[i] = i;
    for (int i = 0; i < 9; i++) ker[i] = 1;
    model(7, 3, 2, 1'b0);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    k = 0; w = 0;
    while (k < 9 && w < 100) begin
      kw_valid_s = 1'b1; kw_in_s = 8'(ker[k]);
      hs = kw_ready_s;
      @(posedge clk); #1;
      if (hs) k++;
      w++;
    end
    kw_valid_s = 1'b0;
    k = 0; w = 0;
    while (k < 49 && w < 200) begin
      pixel_valid_s = 1'b1; pixel_in_s = 8'(img[k]);
      hs = pixel_ready_s;
      @(posedge clk); #1;
      if (hs) k++;
      w++;
    end
    pixel_valid_s = 1'b0;
    check("s_load_done", load_done_s, 1);
    out_ready_s = 1'b1;
    k = 0; w = 0;
    while (k < 9 && w < 300) begin
      if (out_valid_s) begin
        check("s_conv_out", conv_out_s, exp_q[k]);
        check("s_out_row", out_row_s, k / 3);
        check("s_out_col", out_col_s, k % 3);
        if (k == 0) check("s_res_0_0", conv_out_s, 72);
        if (k == 1) check("s_res_0_1", conv_out_s, 90);
        if (k == 8) check("s_res_2_2", conv_out_s, 360);
        k++;
      end
      @(posedge clk); #1;
      w++;
    end
    out_ready_s = 1'b0;
    if (k < 9) timeout("s_results");
    else check("s_done", done_s, 1);
    @(posedge clk); #1;
    check("s_busy_idle", busy_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
